// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory behind a valid/ready request port.
// Each request is answered after a fixed latency: load data, store acknowledge, or a fault.
module dmem_ctrl #(
  parameter int DMEM_BYTES = 4096,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [2:0]  reqSize,
  input  logic [31:0] reqWData,
  output logic        respValid,
  input  logic        respReady,
  output logic [31:0] respRData,
  output logic        respErr
);

  localparam int AW = $clog2(DMEM_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  mem [DMEM_BYTES];

  logic [2:0]    nbytes;
  logic          size_ok, align_ok, range_ok, fault, commit;
  logic [AW-1:0] idx;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_val;

  // Access decode works on the latched request, so the inputs are free while busy.
  always_comb begin
    nbytes   = 3'd0;
    size_ok  = 1'b0;
    align_ok = 1'b1;
    case (size_q)
      3'b000: begin nbytes = 3'd1; size_ok = 1'b1; end
      3'b001: begin nbytes = 3'd2; size_ok = 1'b1; align_ok = ~addr_q[0]; end
      3'b010: begin nbytes = 3'd4; size_ok = 1'b1; align_ok = (addr_q[1:0] == 2'b00); end
      3'b100: begin nbytes = 3'd1; size_ok = ~write_q; end
      3'b101: begin nbytes = 3'd2; size_ok = ~write_q; align_ok = ~addr_q[0]; end
      default: begin nbytes = 3'd0; size_ok = 1'b0; end
    endcase
    range_ok = ({1'b0, addr_q} + {30'd0, nbytes}) <= 33'(DMEM_BYTES);
    fault    = ~(size_ok & align_ok & range_ok);
    commit   = (state_q == BUSY) && (cnt_q == 4'd0);
  end

  // Neighbouring byte indices may wrap; they are only consumed for legal in-range accesses.
  always_comb begin
    idx = addr_q[AW-1:0];
    b0  = mem[idx];
    b1  = mem[idx + AW'(1)];
    b2  = mem[idx + AW'(2)];
    b3  = mem[idx + AW'(3)];
    case (size_q)
      3'b000:  load_val = {{24{b0[7]}}, b0};
      3'b001:  load_val = {{16{b1[7]}}, b1, b0};
      3'b010:  load_val = {b3, b2, b1, b0};
      3'b100:  load_val = {24'd0, b0};
      3'b101:  load_val = {16'd0, b1, b0};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          write_d     = reqWrite;
          addr_d      = reqAddr;
          size_d      = reqSize;
          wdata_d     = reqWData;
          cnt_d       = 4'(LATENCY - 1);
          req_ready_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          err_d        = fault;
          rdata_d      = (!fault && !write_q) ? load_val : 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (respReady) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          rdata_d      = 32'd0;
          err_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      size_q       <= 3'd0;
      wdata_q      <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage has no reset; reset forces IDLE asynchronously, so a pending store never commits.
  always_ff @(posedge clk) begin
    if (commit && write_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(nbytes)) mem[idx + AW'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign reqReady  = req_ready_q;
  assign respValid = resp_valid_q;
  assign respRData = rdata_q;
  assign respErr   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (LATENCY 2, 1, 8) share one request stream and are
// compared against a byte-array reference model; directed cases first, then random traffic.
module tb_dmem_ctrl;
  localparam int DB = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;

  logic ready2, valid2, err2; logic [31:0] rdata2;
  logic ready1, valid1, err1; logic [31:0] rdata1;
  logic ready8, valid8, err8; logic [31:0] rdata8;

  always #5 clk = ~clk;

  dmem_ctrl #(.DMEM_BYTES(DB), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .reqValid(req_valid), .reqReady(ready2), .reqWrite(req_write),
    .reqAddr(req_addr), .reqSize(req_size), .reqWData(req_wdata), .respValid(valid2),
    .respReady(resp_ready), .respRData(rdata2), .respErr(err2));
  dmem_ctrl #(.DMEM_BYTES(DB), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .reqValid(req_valid), .reqReady(ready1), .reqWrite(req_write),
    .reqAddr(req_addr), .reqSize(req_size), .reqWData(req_wdata), .respValid(valid1),
    .respReady(resp_ready), .respRData(rdata1), .respErr(err1));
  dmem_ctrl #(.DMEM_BYTES(DB), .LATENCY(8)) dut_l8 (
    .clk(clk), .rst(rst), .reqValid(req_valid), .reqReady(ready8), .reqWrite(req_write),
    .reqAddr(req_addr), .reqSize(req_size), .reqWData(req_wdata), .respValid(valid8),
    .respReady(resp_ready), .respRData(rdata8), .respErr(err8));

  int n_checks = 0;
  int n_fail   = 0;
  byte unsigned ref_mem [DB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: applies the access rules directly to a byte array.
  task automatic ref_txn(input bit w, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] wd, output logic [31:0] rd, output bit e);
    int nb;
    bit legal_size;
    longint v;
    nb = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : (s[1:0] == 2'd2) ? 4 : 0;
    legal_size = w ? (s <= 3'd2) : (s <= 3'd2 || s == 3'd4 || s == 3'd5);
    e = !legal_size || (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0)
        || (longint'(a) + longint'(nb) > longint'(DB));
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
      end else begin
        v = 0;
        for (int i = nb - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[a + i]);
        if (!s[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
        rd = 32'(v);
      end
    end
  endtask

  // One request through all three instances; latency is counted in edges after acceptance.
  task automatic do_txn(input string tag, input bit w, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit exp_e;
    int lat [3];
    logic [31:0] rd [3];
    logic er [3];
    lat = '{0, 0, 0};
    rd  = '{32'd0, 32'd0, 32'd0};
    er  = '{1'b0, 1'b0, 1'b0};
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, ready2}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ref_txn(w, a, s, wd, exp_rd, exp_e);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (valid1 && lat[0] == 0) begin lat[0] = c; rd[0] = rdata1; er[0] = err1; end
      if (valid2 && lat[1] == 0) begin lat[1] = c; rd[1] = rdata2; er[1] = err2; end
      if (valid8 && lat[2] == 0) begin lat[2] = c; rd[2] = rdata8; er[2] = err8; end
    end
    check({tag, "_lat2"}, 32'(lat[1]), 32'd2);
    check({tag, "_rdata2"}, rd[1], exp_rd);
    check({tag, "_err2"}, {31'd0, er[1]}, {31'd0, exp_e});
    check({tag, "_lat1"}, 32'(lat[0]), 32'd1);
    check({tag, "_rdata1"}, rd[0], exp_rd);
    check({tag, "_err1"}, {31'd0, er[0]}, {31'd0, exp_e});
    check({tag, "_lat8"}, 32'(lat[2]), 32'd8);
    check({tag, "_rdata8"}, rd[2], exp_rd);
    check({tag, "_err8"}, {31'd0, er[2]}, {31'd0, exp_e});
    $display("txn %-12s w=%0d addr=%h size=%0d wdata=%h -> rdata=%h err=%0d lat=%0d/%0d/%0d",
             tag, w, a, s, wd, rd[1], er[1], lat[0], lat[1], lat[2]);
  endtask

  initial begin
    logic [31:0] a;
    int r;

    #2 rst = 1'b1;
    #2;
    check("rst_ready", {31'd0, ready2}, 32'd1);
    check("rst_valid", {31'd0, valid2}, 32'd0);
    check("rst_rdata", rdata2, 32'd0);
    check("rst_err", {31'd0, err2}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    do_txn("st_w_10", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    do_txn("ld_w_10", 1'b0, 32'h10, 3'b010, 32'h0);
    do_txn("ld_b_13", 1'b0, 32'h13, 3'b000, 32'h0);
    do_txn("ld_bu_13", 1'b0, 32'h13, 3'b100, 32'h0);
    do_txn("ld_h_12", 1'b0, 32'h12, 3'b001, 32'h0);
    do_txn("st_h_11", 1'b1, 32'h11, 3'b001, 32'h1234);
    do_txn("ld_w_10b", 1'b0, 32'h10, 3'b010, 32'h0);
    do_txn("ld_w_top2", 1'b0, DB - 2, 3'b010, 32'h0);
    do_txn("st_sz100", 1'b1, 32'h10, 3'b100, 32'h77);
    do_txn("st_w_top4", 1'b1, DB - 4, 3'b010, 32'hCAFEF00D);
    do_txn("ld_w_top4", 1'b0, DB - 4, 3'b010, 32'h0);

    // Response back-pressure: outputs frozen, new requests ignored.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 3'b010;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stall_valid0", {31'd0, valid2}, 32'd1);
    check("stall_rdata0", rdata2, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_size = 3'b010; req_wdata = 32'h0;
      @(posedge clk); #1;
      check("stall_valid", {31'd0, valid2}, 32'd1);
      check("stall_rdata", rdata2, 32'hDEADBEEF);
      check("stall_err", {31'd0, err2}, 32'd0);
      check("stall_ready", {31'd0, ready2}, 32'd0);
      check("stall_valid_l1", {31'd0, valid1}, 32'd1);
      $display("stall cycle %0d valid=%0d rdata=%h ready=%0d", k, valid2, rdata2, ready2);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", {31'd0, valid2}, 32'd0);
    check("release_ready", {31'd0, ready2}, 32'd1);
    repeat (10) @(posedge clk);
    do_txn("ld_w_10c", 1'b0, 32'h10, 3'b010, 32'h0);

    // Reset while a store is in flight must drop the store.
    do_txn("st_w_20", 1'b1, 32'h20, 3'b010, 32'h01020304);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_ready", {31'd0, ready2}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {31'd0, ready2}, 32'd1);
    check("arst_valid", {31'd0, valid2}, 32'd0);
    check("arst_rdata", rdata2, 32'd0);
    check("arst_err", {31'd0, err2}, 32'd0);
    check("arst_ready_l1", {31'd0, ready1}, 32'd1);
    check("arst_ready_l8", {31'd0, ready8}, 32'd1);
    $display("async reset in BUSY: ready=%0d valid=%0d rdata=%h err=%0d", ready2, valid2, rdata2, err2);
    @(negedge clk); rst = 1'b0;
    do_txn("ld_w_20", 1'b0, 32'h20, 3'b010, 32'h0);

    for (int i = 0; i < 16; i++)
      do_txn("fill", 1'b1, 32'h100 + 32'(4 * i), 3'b010, $urandom);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'h100 + 32'($urandom_range(0, 63));
      else if (r == 8) a = DB - 4 + 32'($urandom_range(0, 4));
      else             a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      do_txn("rand", 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DMEM_BYTES, default 4096, byte capacity (power of two, >= 4).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (legal 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port reqValid  input  1  request present.
REQ-006 SHALL have port reqReady  output  1  request can be accepted.
REQ-007 SHALL have port reqWrite  input  1  1 = store, 0 = load.
REQ-008 SHALL have port reqAddr  input  32  byte address.
REQ-009 SHALL have port reqSize  input  3  funct3 access code.
REQ-010 SHALL have port reqWData  input  32  store data, right-aligned.
REQ-011 SHALL have port respValid  output  1  response present.
REQ-012 SHALL have port respReady  input  1  consumer accepts response.
REQ-013 SHALL have port respRData  output  32  load result, extended.
REQ-014 SHALL have port respErr  output  1  request faulted.

Function
REQ-015 SHALL hold DMEM_BYTES bytes of storage, little-endian (byte at addr in bits 7:0).
REQ-016 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; reqReady = 1 only in IDLE; respValid = 1 only in RESP.
REQ-017 SHALL accept a request on an edge with reqValid & reqReady, latching write, addr, size, wdata, and loading the latency counter with LATENCY-1.
REQ-018 SHALL in BUSY decrement the counter each edge and enter RESP on the edge where the counter is 0, so respValid first rises exactly LATENCY cycles after the acceptance edge.
REQ-019 SHALL decode sizes: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; loads allow all five, stores allow 000/001/010 only.
REQ-020 SHALL flag an error when the size is illegal for the op, a half access has addr[0] = 1, a word access has addr[1:0] != 0, or addr + access bytes > DMEM_BYTES (computed without 32-bit wrap).
REQ-021 SHALL for a legal store write only the 1/2/4 addressed bytes on the edge entering RESP; other bytes unchanged; respRData = 0, respErr = 0.
REQ-022 SHALL for a legal load capture the sign- or zero-extended value into respRData on the edge entering RESP; respErr = 0.
REQ-023 SHALL for a faulted request follow identical timing, leave memory unmodified, and present respRData = 0, respErr = 1.
REQ-024 SHALL hold respValid, respRData and respErr stable in RESP until an edge with respReady = 1, then return to IDLE; the next request is accepted no earlier than the following edge.
REQ-025 SHALL ignore reqValid and all request inputs while not in IDLE.
REQ-026 SHALL make a load issued after a completed store to the same bytes return the stored data.

Reset
REQ-027 SHALL on rst = 1 immediately force IDLE, counter 0, reqReady = 1, respValid = 0, respRData = 0, respErr = 0.
REQ-028 SHALL discard an in-flight request on reset: a store not yet committed does not modify memory.
REQ-029 SHALL NOT clear memory contents on reset.

Verification
REQ-030 SHALL cover: LATENCY=2, store word 0xDEADBEEF @0x10, then load word @0x10 -> respValid 2 cycles after each acceptance, rdata 0xDEADBEEF, err 0.
REQ-031 SHALL cover: after REQ-030, load byte signed @0x13 -> 0xFFFFFFDE; byte unsigned @0x13 -> 0x000000DE; half signed @0x12 -> 0xFFFFDEAD.
REQ-032 SHALL cover: store half 0x1234 @0x11 -> respErr 1, rdata 0; load word @0x10 still 0xDEADBEEF.
REQ-033 SHALL cover: load word @DMEM_BYTES-2 and store size 100 -> both respErr 1; load word @DMEM_BYTES-4 -> respErr 0.
REQ-034 SHALL cover: respReady held 0 for 5 cycles -> respValid and data stable, reqReady 0, a new reqValid ignored; LATENCY=1 and LATENCY=8 timing checked.
REQ-035 SHALL cover: store word 0x55AA55AA @0x20 accepted, rst asserted asynchronously in BUSY -> outputs reset at once; load word @0x20 returns prior contents.
